axis_weight_loader: RTL and testbench

- Hardware weight-preload transmitter for the MVM mesh.
- Accepts 512-bit weight rows through a dispatcher-style FIFO write port.
- Wraps each row as one AXI-S flit: MVM weight-write header appended above tdata, tdest set to the target MVM node.
- Streams the flits into a mesh ingress port, standing in for the bench-driven weight path at the weight-loader node.

---
 rtl/axis_weight_loader.sv | 249 ++++++++++++++++++++++++
 tb/tb_axis_weight_loader.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_weight_loader.sv
// -----------------------------------------------------------------------------
// axis_weight_loader
//
// Weight-preload transmitter for the MVM mesh. Weight rows are pushed through a
// dispatcher-style FIFO write port. Each row goes out as one AXI-Stream flit
// whose tdata is {MVM weight-write header, row} and whose tdest is the target
// MVM node. The flits stream into a mesh ingress port.
//
// Header layout (the bits of tdata above DATAW):
//   [ADDRW-1:0]            register-file address (row index within a DPE)
//   [ADDRW+1:ADDRW]        2'b11, the weight-write opcode
//   [ADDRW+1+DPES:ADDRW+2] one-hot rf_en that selects the DPE
//   remaining bits         0
//
// Optional feature, macro WLOAD_BCAST_EN: adds input cfg_bcast, which is
// latched with cfg_start. When it is latched high, rf_en is all ones,
// exactly cfg_rows flits are sent, and tlast marks only the final flit.
//
// Ports:
//   clk, rst_n           clock; asynchronous active-low reset
//   cfg_start            start pulse, sampled only while idle
//   cfg_node             destination node, driven on tdest
//   cfg_num_dpes         number of DPEs to load, starting at DPE 0
//   cfg_rows             rows per DPE (0..2^ADDRW)
//   cfg_bcast            broadcast select (only with WLOAD_BCAST_EN)
//   busy, done           transfer in progress / one-cycle completion pulse
//   data_fifo_*          row push port; rdy is high while the FIFO is not full
//   axis_tx_*            AXI-Stream master into the mesh
// -----------------------------------------------------------------------------
module axis_weight_loader #(
    parameter int DATAW      = 512,
    parameter int USERW      = 75,
    parameter int DPES       = 64,
    parameter int ADDRW      = 9,
    parameter int IDW        = 2,
    parameter int DESTW      = 4,
    parameter int TID_VALUE  = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_start,
    input  logic [DESTW-1:0]        cfg_node,
    input  logic [$clog2(DPES):0]   cfg_num_dpes,
    input  logic [ADDRW:0]          cfg_rows,
`ifdef WLOAD_BCAST_EN
    input  logic                    cfg_bcast,
`endif
    output logic                    busy,
    output logic                    done,
    input  logic                    data_fifo_wen,
    input  logic [DATAW-1:0]        data_fifo_wdata,
    output logic                    data_fifo_rdy,
    output logic                    axis_tx_tvalid,
    input  logic                    axis_tx_tready,
    output logic [DATAW+USERW-1:0]  axis_tx_tdata,
    output logic [IDW-1:0]          axis_tx_tid,
    output logic [DESTW-1:0]        axis_tx_tdest,
    output logic                    axis_tx_tlast
);

    localparam int NDW = $clog2(DPES) + 1;
    localparam int RW  = ADDRW + 1;
    localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW  = PW + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SEND  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // ------------------------------------------------------------------
    // Input FIFO
    // ------------------------------------------------------------------
    logic [DATAW-1:0] fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;

    assign fifo_full     = (count_reg == CW'(FIFO_DEPTH));
    assign fifo_empty    = (count_reg == '0);
    assign data_fifo_rdy = ~fifo_full;
    // A push that lands on a full FIFO is still accepted when the head
    // leaves in the same cycle, so occupancy stays at the limit.
    assign push          = data_fifo_wen & (~fifo_full | pop);

    // Storage has no reset so it maps onto RAM; the output stage below
    // provides the registered read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= data_fifo_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            count_reg <= count_reg + CW'(push) - CW'(pop);
        end
    end

    // ------------------------------------------------------------------
    // Transfer control
    // ------------------------------------------------------------------
    logic [1:0]             state_reg;
    logic [DESTW-1:0]       node_reg;
    logic [NDW-1:0]         num_dpes_reg;
    logic [RW-1:0]          rows_reg;
    logic [NDW-1:0]         dpe_cnt_reg;
    logic [ADDRW-1:0]       addr_cnt_reg;
    logic                   tvalid_reg;
    logic                   tlast_reg;
    logic [DATAW+USERW-1:0] tdata_reg;
    logic                   busy_reg;
    logic                   done_reg;
    logic                   bcast_mode;

`ifdef WLOAD_BCAST_EN
    logic bcast_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcast_reg <= 1'b0;
        end else if (state_reg == ST_IDLE && cfg_start) begin
            bcast_reg <= cfg_bcast;
        end
    end

    assign bcast_mode = bcast_reg;
`else
    assign bcast_mode = 1'b0;
`endif

    logic fire;
    logic last_addr;
    logic last_dpe;
    logic final_load;
    logic empty_cfg;

    assign fire       = tvalid_reg & axis_tx_tready;
    // The output stage refills when it is empty or being emptied this cycle.
    assign pop        = (state_reg == ST_SEND) & (~tvalid_reg | fire) & ~fifo_empty;
    assign last_addr  = ({1'b0, addr_cnt_reg} == (rows_reg - RW'(1)));
    // Broadcast writes every DPE with each flit, so one pass over the
    // rows finishes the transfer.
    assign last_dpe   = bcast_mode | (dpe_cnt_reg == (num_dpes_reg - NDW'(1)));
    assign final_load = last_addr & last_dpe;
    assign empty_cfg  = (cfg_num_dpes == '0) | (cfg_rows == '0);

    // rf_en one-hot, or all ones in broadcast mode.
    logic [DPES-1:0]  rf_en;
    logic [USERW-1:0] hdr;

    genvar gi;
    generate
        for (gi = 0; gi < DPES; gi++) begin : g_rf_en
            assign rf_en[gi] = bcast_mode | (dpe_cnt_reg == NDW'(gi));
        end
    endgenerate

    assign hdr = USERW'({rf_en, 2'b11, addr_cnt_reg});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            node_reg     <= '0;
            num_dpes_reg <= '0;
            rows_reg     <= '0;
            dpe_cnt_reg  <= '0;
            addr_cnt_reg <= '0;
            tvalid_reg   <= 1'b0;
            tlast_reg    <= 1'b0;
            tdata_reg    <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (cfg_start) begin
                        node_reg     <= cfg_node;
                        num_dpes_reg <= cfg_num_dpes;
                        rows_reg     <= cfg_rows;
                        dpe_cnt_reg  <= '0;
                        addr_cnt_reg <= '0;
                        if (empty_cfg) begin
                            done_reg <= 1'b1;
                        end else begin
                            state_reg <= ST_SEND;
                            busy_reg  <= 1'b1;
                        end
                    end
                end
                ST_SEND: begin
                    if (pop) begin
                        tdata_reg  <= {hdr, fifo_mem[rd_ptr_reg]};
                        tvalid_reg <= 1'b1;
                        // In broadcast mode last_dpe is always true, so this
                        // still marks only the final flit.
                        tlast_reg  <= last_addr;
                        if (last_addr) begin
                            addr_cnt_reg <= '0;
                            dpe_cnt_reg  <= dpe_cnt_reg + NDW'(1);
                        end else begin
                            addr_cnt_reg <= addr_cnt_reg + ADDRW'(1);
                        end
                        if (final_load) begin
                            state_reg <= ST_DRAIN;
                        end
                    end else if (fire) begin
                        tvalid_reg <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (fire) begin
                        tvalid_reg <= 1'b0;
                        busy_reg   <= 1'b0;
                        done_reg   <= 1'b1;
                        state_reg  <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy           = busy_reg;
    assign done           = done_reg;
    assign axis_tx_tvalid = tvalid_reg;
    assign axis_tx_tdata  = tdata_reg;
    assign axis_tx_tlast  = tlast_reg;
    assign axis_tx_tdest  = node_reg;
    assign axis_tx_tid    = IDW'(TID_VALUE);

endmodule

// File: tb/tb_axis_weight_loader.sv
// -----------------------------------------------------------------------------
// tb_axis_weight_loader
//
// Scoreboard bench for axis_weight_loader. Header expectations are queued when
// a start is issued, and row data is queued when a push is accepted. A negedge
// monitor pops both queues on each handshake and compares the result with the
// flit. The monitor also checks that a stalled flit holds stable and that busy
// is low whenever done pulses. Each scenario task adds its own checks on
// counts and status.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axis_weight_loader;

    localparam int DATAW = 512;
    localparam int USERW = 75;
    localparam int TW    = DATAW + USERW;

    logic             clk;
    logic             rst_n;
    logic             cfg_start;
    logic [3:0]       cfg_node;
    logic [6:0]       cfg_num_dpes;
    logic [9:0]       cfg_rows;
    logic             cfg_bcast;
    logic             busy;
    logic             done;
    logic             data_fifo_wen;
    logic [DATAW-1:0] data_fifo_wdata;
    logic             data_fifo_rdy;
    logic             axis_tx_tvalid;
    logic             axis_tx_tready;
    logic [TW-1:0]    axis_tx_tdata;
    logic [1:0]       axis_tx_tid;
    logic [3:0]       axis_tx_tdest;
    logic             axis_tx_tlast;

    axis_weight_loader dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cfg_start       (cfg_start),
        .cfg_node        (cfg_node),
        .cfg_num_dpes    (cfg_num_dpes),
        .cfg_rows        (cfg_rows),
`ifdef WLOAD_BCAST_EN
        .cfg_bcast       (cfg_bcast),
`endif
        .busy            (busy),
        .done            (done),
        .data_fifo_wen   (data_fifo_wen),
        .data_fifo_wdata (data_fifo_wdata),
        .data_fifo_rdy   (data_fifo_rdy),
        .axis_tx_tvalid  (axis_tx_tvalid),
        .axis_tx_tready  (axis_tx_tready),
        .axis_tx_tdata   (axis_tx_tdata),
        .axis_tx_tid     (axis_tx_tid),
        .axis_tx_tdest   (axis_tx_tdest),
        .axis_tx_tlast   (axis_tx_tlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [USERW-1:0] hdr;
        logic             last;
        logic [3:0]       dest;
    } exp_t;

    exp_t             exp_q[$];
    logic [DATAW-1:0] row_q[$];

    int n_cmp      = 0;
    int n_err      = 0;
    int flit_cnt   = 0;
    int done_cnt   = 0;
    int bubble_cnt = 0;
    int stall_cnt  = 0;
    logic [USERW-1:0] last_hdr;

    // Header reference: {rf_en, 2'b11, addr}, with rf_en one-hot or all ones.
    function automatic logic [USERW-1:0] hdr_f(input int dpe, input int addr, input bit bc);
        logic [USERW-1:0] h;
        h = '0;
        h[8:0]  = addr[8:0];
        h[10:9] = 2'b11;
        if (bc) h[74:11] = '1;
        else    h[11 + dpe] = 1'b1;
        return h;
    endfunction

    function automatic logic [DATAW-1:0] rand_row();
        logic [DATAW-1:0] r;
        for (int i = 0; i < DATAW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Output monitor / scoreboard
    // ------------------------------------------------------------------
    logic          prev_stall;
    logic [TW-1:0] prev_data;
    logic          prev_last;
    logic [3:0]    prev_dest;

    always @(negedge clk) begin
        exp_t             e;
        logic [DATAW-1:0] r;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                n_cmp++;
                if (!(axis_tx_tvalid === 1'b1 && axis_tx_tdata === prev_data &&
                      axis_tx_tlast === prev_last && axis_tx_tdest === prev_dest)) begin
                    n_err++;
                    $display("FAIL stall_hold: got valid=%b hdr=%h last=%b dest=%0d, need valid=1 hdr=%h last=%b dest=%0d",
                             axis_tx_tvalid, axis_tx_tdata[TW-1:DATAW], axis_tx_tlast, axis_tx_tdest,
                             prev_data[TW-1:DATAW], prev_last, prev_dest);
                end
            end
            if (done === 1'b1) begin
                done_cnt++;
                n_cmp++;
                if (busy !== 1'b0) begin
                    n_err++;
                    $display("FAIL busy_at_done: got busy=%b, need 0", busy);
                end
            end
            if (busy === 1'b1 && axis_tx_tvalid === 1'b0) bubble_cnt++;
            if (axis_tx_tvalid === 1'b1 && axis_tx_tready === 1'b1) begin
                flit_cnt++;
                n_cmp++;
                last_hdr = axis_tx_tdata[TW-1:DATAW];
                if (exp_q.size() == 0 || row_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_flit: got hdr=%h, need no flit (exp=%0d rows=%0d)",
                             axis_tx_tdata[TW-1:DATAW], exp_q.size(), row_q.size());
                end else begin
                    e = exp_q.pop_front();
                    r = row_q.pop_front();
                    if (axis_tx_tdata !== {e.hdr, r} || axis_tx_tdest !== e.dest ||
                        axis_tx_tlast !== e.last || axis_tx_tid !== 2'd0) begin
                        n_err++;
                        $display("FAIL flit%0d: got hdr=%h dest=%0d last=%b tid=%0d row_lo=%h, need hdr=%h dest=%0d last=%b tid=0 row_lo=%h",
                                 flit_cnt, axis_tx_tdata[TW-1:DATAW], axis_tx_tdest, axis_tx_tlast,
                                 axis_tx_tid, axis_tx_tdata[63:0], e.hdr, e.dest, e.last, r[63:0]);
                    end
                end
            end
            if (axis_tx_tvalid === 1'b1 && axis_tx_tready === 1'b0) stall_cnt++;
            prev_stall = axis_tx_tvalid & ~axis_tx_tready;
            prev_data  = axis_tx_tdata;
            prev_last  = axis_tx_tlast;
            prev_dest  = axis_tx_tdest;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus primitives
    // ------------------------------------------------------------------
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push_row(input logic [DATAW-1:0] d, input bit expect_accept);
        data_fifo_wen   = 1'b1;
        data_fifo_wdata = d;
        if (expect_accept) row_q.push_back(d);
        cycle();
        data_fifo_wen   = 1'b0;
    endtask

    task automatic start_x(input logic [3:0] node, input int nd, input int rows, input bit bc);
        exp_t e;
        if (nd != 0 && rows != 0) begin
            if (bc) begin
                for (int a = 0; a < rows; a++) begin
                    e.hdr = hdr_f(0, a, 1'b1); e.last = (a == rows - 1); e.dest = node;
                    exp_q.push_back(e);
                end
            end else begin
                for (int d = 0; d < nd; d++)
                    for (int a = 0; a < rows; a++) begin
                        e.hdr = hdr_f(d, a, 1'b0); e.last = (a == rows - 1); e.dest = node;
                        exp_q.push_back(e);
                    end
            end
        end
        cfg_node     = node;
        cfg_num_dpes = 7'(nd);
        cfg_rows     = 10'(rows);
        cfg_bcast    = bc;
        cfg_start    = 1'b1;
        cycle();
        cfg_start    = 1'b0;
    endtask

    // Feeds npush rows (gap cycles apart) while driving tready, and stops at done.
    task automatic run_flow(input int npush, input int gap, input bit bp, input int budget);
        int d0;
        d0 = done_cnt;
        fork
            begin
                for (int i = 0; i < npush; i++) begin
                    int t;
                    t = 0;
                    while (data_fifo_rdy !== 1'b1 && t < 200) begin cycle(); t++; end
                    if (data_fifo_rdy !== 1'b1) begin
                        n_cmp++; n_err++;
                        $display("FAIL push_timeout: got rdy=%b, need 1 within 200 cycles", data_fifo_rdy);
                        break;
                    end
                    push_row(rand_row(), 1'b1);
                    repeat (gap - 1) cycle();
                end
            end
            begin
                int k;
                for (k = 0; k < budget; k++) begin
                    if (done_cnt > d0) break;
                    axis_tx_tready = bp ? ((k % 4) == 0 || (k % 4) == 3) : 1'b1;
                    cycle();
                end
                if (done_cnt == d0) begin
                    n_cmp++; n_err++;
                    $display("FAIL done_timeout: got no done, need done within %0d cycles", budget);
                end
            end
        join
        axis_tx_tready = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        n_cmp += 7;
        if (axis_tx_tvalid !== 1'b0) begin n_err++; $display("FAIL rst_tvalid: got %b need 0", axis_tx_tvalid); end
        if (axis_tx_tlast !== 1'b0)  begin n_err++; $display("FAIL rst_tlast: got %b need 0", axis_tx_tlast); end
        if (axis_tx_tdata !== '0)    begin n_err++; $display("FAIL rst_tdata: got hdr=%h need 0", axis_tx_tdata[TW-1:DATAW]); end
        if (axis_tx_tdest !== 4'd0)  begin n_err++; $display("FAIL rst_tdest: got %0d need 0", axis_tx_tdest); end
        if (busy !== 1'b0)           begin n_err++; $display("FAIL rst_busy: got %b need 0", busy); end
        if (done !== 1'b0)           begin n_err++; $display("FAIL rst_done: got %b need 0", done); end
        if (data_fifo_rdy !== 1'b1)  begin n_err++; $display("FAIL rst_rdy: got %b need 1", data_fifo_rdy); end
        @(posedge clk); #1 rst_n = 1'b1;
        cycle();
        n_cmp++;
        if (axis_tx_tvalid !== 1'b0) begin n_err++; $display("FAIL post_rst_tvalid: got %b need 0", axis_tx_tvalid); end
    endtask

    task automatic test_basic();
        int f0, d0;
        f0 = flit_cnt; d0 = done_cnt;
        axis_tx_tready = 1'b1;
        for (int i = 0; i < 4; i++) push_row(rand_row(), 1'b1);
        start_x(4'd3, 2, 3, 1'b0);
        n_cmp++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy: got %b need 1", busy); end
        run_flow(2, 1, 1'b0, 100);
        repeat (3) cycle();
        n_cmp += 3;
        if (flit_cnt - f0 != 6) begin n_err++; $display("FAIL basic_flits: got %0d need 6", flit_cnt - f0); end
        if (done_cnt - d0 != 1) begin n_err++; $display("FAIL basic_done: got %0d need 1", done_cnt - d0); end
        if (exp_q.size() != 0 || row_q.size() != 0) begin
            n_err++; $display("FAIL basic_left: got exp=%0d rows=%0d need 0/0", exp_q.size(), row_q.size());
        end
    endtask

    task automatic test_backpressure();
        int f0, s0;
        f0 = flit_cnt; s0 = stall_cnt;
        axis_tx_tready = 1'b0;
        for (int i = 0; i < 4; i++) push_row(rand_row(), 1'b1);
        start_x(4'd3, 2, 3, 1'b0);
        run_flow(2, 1, 1'b1, 200);
        repeat (2) cycle();
        n_cmp += 3;
        if (flit_cnt - f0 != 6) begin n_err++; $display("FAIL bp_flits: got %0d need 6", flit_cnt - f0); end
        if (stall_cnt == s0) begin n_err++; $display("FAIL bp_stalls: got 0 stalled cycles, need >0"); end
        if (exp_q.size() != 0) begin n_err++; $display("FAIL bp_left: got %0d need 0", exp_q.size()); end
    endtask

    task automatic test_starvation();
        int f0, b0;
        f0 = flit_cnt; b0 = bubble_cnt;
        start_x(4'd7, 2, 3, 1'b0);
        run_flow(6, 4, 1'b0, 200);
        repeat (2) cycle();
        n_cmp += 2;
        if (flit_cnt - f0 != 6) begin n_err++; $display("FAIL starve_flits: got %0d need 6", flit_cnt - f0); end
        if (bubble_cnt == b0) begin n_err++; $display("FAIL starve_bubbles: got 0 bubbles, need >0"); end
    endtask

    task automatic test_empty_transfer();
        int f0;
        f0 = flit_cnt;
        start_x(4'd2, 2, 0, 1'b0);
        n_cmp += 2;
        if (done !== 1'b1) begin n_err++; $display("FAIL rows0_done: got %b need 1", done); end
        if (busy !== 1'b0) begin n_err++; $display("FAIL rows0_busy: got %b need 0", busy); end
        cycle();
        n_cmp++;
        if (done !== 1'b0) begin n_err++; $display("FAIL rows0_done_len: got %b need 0", done); end
        start_x(4'd2, 0, 5, 1'b0);
        n_cmp += 2;
        if (done !== 1'b1) begin n_err++; $display("FAIL dpes0_done: got %b need 1", done); end
        if (flit_cnt != f0) begin n_err++; $display("FAIL empty_flits: got %0d need 0", flit_cnt - f0); end
        cycle();
    endtask

    task automatic test_large();
        int f0;
        f0 = flit_cnt;
        start_x(4'd1, 64, 512, 1'b0);
        run_flow(64 * 512, 1, 1'b0, 40000);
        repeat (2) cycle();
        n_cmp += 2;
        if (flit_cnt - f0 != 64 * 512) begin n_err++; $display("FAIL large_flits: got %0d need %0d", flit_cnt - f0, 64 * 512); end
        if (last_hdr !== hdr_f(63, 511, 1'b0)) begin
            n_err++; $display("FAIL large_last_hdr: got %h need %h", last_hdr, hdr_f(63, 511, 1'b0));
        end
    endtask

    task automatic test_full_fifo();
        int f0;
        f0 = flit_cnt;
        axis_tx_tready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (data_fifo_rdy !== 1'b1) begin n_err++; $display("FAIL full_rdy_pre%0d: got %b need 1", i, data_fifo_rdy); end
            push_row(rand_row(), 1'b1);
        end
        n_cmp++;
        if (data_fifo_rdy !== 1'b0) begin n_err++; $display("FAIL full_rdy: got %b need 0", data_fifo_rdy); end
        push_row(rand_row(), 1'b0);
        n_cmp++;
        if (data_fifo_rdy !== 1'b0) begin n_err++; $display("FAIL full_rdy_after: got %b need 0", data_fifo_rdy); end
        start_x(4'd6, 1, 4, 1'b0);
        run_flow(0, 1, 1'b0, 50);
        repeat (2) cycle();
        n_cmp += 2;
        if (flit_cnt - f0 != 4) begin n_err++; $display("FAIL full_flits: got %0d need 4", flit_cnt - f0); end
        if (data_fifo_rdy !== 1'b1) begin n_err++; $display("FAIL full_drained_rdy: got %b need 1", data_fifo_rdy); end
    endtask

    task automatic test_reset_restart();
        int f0, d0, t;
        f0 = flit_cnt; d0 = done_cnt;
        axis_tx_tready = 1'b1;
        for (int i = 0; i < 4; i++) push_row(rand_row(), 1'b1);
        start_x(4'd2, 2, 3, 1'b0);
        t = 0;
        while (flit_cnt - f0 < 2 && t < 20) begin cycle(); t++; end
        n_cmp++;
        if (flit_cnt - f0 != 2) begin n_err++; $display("FAIL rr_pre_flits: got %0d need 2", flit_cnt - f0); end
        axis_tx_tready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_cmp += 3;
        if (axis_tx_tvalid !== 1'b0) begin n_err++; $display("FAIL rr_tvalid: got %b need 0", axis_tx_tvalid); end
        if (data_fifo_rdy !== 1'b1)  begin n_err++; $display("FAIL rr_rdy: got %b need 1", data_fifo_rdy); end
        if (busy !== 1'b0)           begin n_err++; $display("FAIL rr_busy: got %b need 0", busy); end
        exp_q.delete();
        row_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        cycle();
        n_cmp++;
        if (done_cnt != d0) begin n_err++; $display("FAIL rr_no_done: got %0d pulses need 0", done_cnt - d0); end
        // Restart; a second start while busy must be ignored.
        f0 = flit_cnt;
        for (int i = 0; i < 2; i++) push_row(rand_row(), 1'b1);
        start_x(4'd5, 1, 3, 1'b0);
        cfg_node = 4'd9; cfg_num_dpes = 7'd2; cfg_rows = 10'd1; cfg_start = 1'b1;
        cycle();
        cfg_start = 1'b0;
        n_cmp++;
        if (axis_tx_tdest !== 4'd5) begin n_err++; $display("FAIL rr_tdest: got %0d need 5", axis_tx_tdest); end
        run_flow(1, 1, 1'b0, 100);
        repeat (2) cycle();
        n_cmp += 2;
        if (flit_cnt - f0 != 3) begin n_err++; $display("FAIL rr_flits: got %0d need 3", flit_cnt - f0); end
        if (exp_q.size() != 0) begin n_err++; $display("FAIL rr_left: got %0d need 0", exp_q.size()); end
    endtask

`ifdef WLOAD_BCAST_EN
    task automatic test_bcast();
        int f0;
        f0 = flit_cnt;
        axis_tx_tready = 1'b1;
        for (int i = 0; i < 2; i++) push_row(rand_row(), 1'b1);
        start_x(4'd4, 5, 2, 1'b1);
        run_flow(0, 1, 1'b0, 50);
        repeat (2) cycle();
        n_cmp++;
        if (flit_cnt - f0 != 2) begin n_err++; $display("FAIL bcast_flits: got %0d need 2", flit_cnt - f0); end
    endtask
`endif

    initial begin
        rst_n           = 1'b0;
        cfg_start       = 1'b0;
        cfg_node        = '0;
        cfg_num_dpes    = '0;
        cfg_rows        = '0;
        cfg_bcast       = 1'b0;
        data_fifo_wen   = 1'b0;
        data_fifo_wdata = '0;
        axis_tx_tready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_backpressure();
        test_starvation();
        test_empty_transfer();
        test_full_fifo();
        test_reset_restart();
`ifdef WLOAD_BCAST_EN
        test_bcast();
`endif
        test_large();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no finish, need finish before 3 ms");
        $fatal(1, "watchdog expired");
    end

endmodule
